rx_arq_frame_buffer: RTL

Parametrised receive payload buffer that sits between the demapper and the UART TX path. It replaces the flush-on-CRC-error FIFO and its fixed delay line with per-frame commit/rollback. Demapped bytes are written speculatively. A frame becomes readable only after the demapper reports its CRC result. A failed frame with ARQ enabled is rewound to the last commit point, so committed data from earlier frames is never lost.

---
 rtl/rx_arq_frame_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rx_arq_frame_buffer.sv
// Receive payload buffer with per-frame commit/rollback between the demapper and UART TX; registered output stage.
// Optional RXBUF_STATS_EN adds saturating commit/drop counters.
module rx_arq_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              i_crc_valid,
  input  logic              i_crc_err,
  input  logic              i_arq_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   o_avail,
  output logic              o_frame_drop
`ifdef RXBUF_STATS_EN
  ,
  output logic [15:0]       o_commit_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [ADDR_W:0]   w_used, w_uncm, w_wr_nxt, w_cm_nxt, w_rd_nxt;
  logic              w_accept, w_wr_en, w_commit, w_rollback, w_load, w_mvalid_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rd_dat;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic [ADDR_W:0]   r_avail;
  logic              r_drop;

  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_uncm = r_wr_ptr - r_cm_ptr;

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    if (!i_rst) begin
      // DROP keeps s_ready high so an oversized frame is swallowed instead of stalling the demapper
      s_ready    = (w_used < LP_DEPTH) || (r_state == ST_DROP);
      w_accept   = s_valid && s_ready;
      w_rollback = i_crc_valid && ((i_crc_err && i_arq_en) || (r_state == ST_DROP));
      w_commit   = i_crc_valid && !w_rollback;
      w_wr_en    = w_accept && (r_state != ST_DROP) && !w_rollback;
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_FILL;
        ST_FILL: if ((w_uncm == LP_DEPTH) && s_valid) w_state_nxt = ST_DROP;
        ST_DROP: w_state_nxt = ST_DROP;
        default: w_state_nxt = ST_IDLE;
      endcase
      if (i_crc_valid) w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_wr_nxt = w_rollback ? r_cm_ptr : (r_wr_ptr + (ADDR_W + 1)'(w_wr_en));
  assign w_cm_nxt = w_commit ? w_wr_nxt : r_cm_ptr;

  // Loading against the next commit pointer gives m_valid the cycle after a commit;
  // a one-word frame committed alongside its write is forwarded straight from s_data.
  assign w_load       = (w_cm_nxt != r_rd_ptr) && (!r_m_valid || m_ready);
  assign w_rd_nxt     = r_rd_ptr + (ADDR_W + 1)'(w_load);
  assign w_rd_dat     = (w_wr_en && (r_rd_ptr == r_wr_ptr)) ? s_data : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_mvalid_nxt = w_load || (r_m_valid && !m_ready);

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= s_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_avail   <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_nxt;
      r_cm_ptr  <= w_cm_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_m_valid <= w_mvalid_nxt;
      if (w_load) r_m_data <= w_rd_dat;
      r_avail   <= (w_cm_nxt - w_rd_nxt) + (ADDR_W + 1)'(w_mvalid_nxt);
      r_drop    <= w_rollback;
    end
  end

  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign o_avail      = r_avail;
  assign o_frame_drop = r_drop;

`ifdef RXBUF_STATS_EN
  logic [15:0] r_commit_cnt, r_drop_cnt;
  logic        w_commit_nonempty;

  assign w_commit_nonempty = w_commit && (w_cm_nxt != r_cm_ptr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_commit_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_commit_nonempty && (r_commit_cnt != 16'hFFFF)) r_commit_cnt <= r_commit_cnt + 16'd1;
      if (w_rollback && (r_drop_cnt != 16'hFFFF))          r_drop_cnt   <= r_drop_cnt + 16'd1;
    end
  end

  assign o_commit_cnt = r_commit_cnt;
  assign o_drop_cnt   = r_drop_cnt;
`endif

endmodule
